// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: reads operands from a local register file, issues one ALU op
// at a time over req/ack, writes the result back and pulses done.
// Latency: accept -> alu_req next cycle; ack -> done_valid next cycle (3-cycle min spacing).
// Backpressure: cmd_ready only in IDLE; ALU stall bounded by TIMEOUT cycles, then error.
// Optional feature: define ALU_STATS_EN to add stat_ops / stat_timeouts counters.
module alu_cmd_issuer #(
  parameter int DATA_W  = 32,
  parameter int OP_W    = 4,
  parameter int NREGS   = 8,
  parameter int TIMEOUT = 255,
  localparam int RA_W   = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [RA_W-1:0]   cmd_rs1,
  input  logic [RA_W-1:0]   cmd_rs2,
  input  logic              cmd_imm_en,
  input  logic [DATA_W-1:0] cmd_imm,
  input  logic [RA_W-1:0]   cmd_rd,
  output logic              alu_req,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic              alu_ack,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [3:0]        alu_flags,
  output logic              done_valid,
  output logic [RA_W-1:0]   done_rd,
  output logic [DATA_W-1:0] done_data,
  output logic [3:0]        done_flags,
  output logic              done_err,
  input  logic [RA_W-1:0]   dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
`ifdef ALU_STATS_EN
  output logic [15:0]       stat_ops,
  output logic [15:0]       stat_timeouts,
`endif
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WRITE} state_t;

  // Last counter value at which a missing ack aborts the request, so alu_req
  // stays high for exactly TIMEOUT cycles.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t            state, state_nxt;
  logic [DATA_W-1:0] regs [NREGS];
  logic [RA_W-1:0]   rd_q;
  logic [15:0]       cnt;
  logic              accept;
  logic              tmo_hit;

  assign accept  = cmd_valid && cmd_ready;
  assign tmo_hit = (cnt == TMO_LAST);

  // Register 0 is never written, so it always reads back as zero.
  assign dbg_data = regs[dbg_addr];

  // State register; reset abandons any in-flight command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs; ack takes priority over timeout.
  always_comb begin
    state_nxt  = state;
    cmd_ready  = 1'b0;
    alu_req    = 1'b0;
    done_valid = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) state_nxt = ISSUE;
      end
      ISSUE: begin
        alu_req = 1'b1;
        if (alu_ack || tmo_hit) state_nxt = WRITE;
      end
      WRITE: begin
        done_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, result capture, timeout count and register write-back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      alu_op     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      rd_q       <= '0;
      cnt        <= '0;
      done_rd    <= '0;
      done_data  <= '0;
      done_flags <= '0;
      done_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            alu_op <= cmd_op;
            alu_a  <= regs[cmd_rs1];
            alu_b  <= cmd_imm_en ? cmd_imm : regs[cmd_rs2];
            rd_q   <= cmd_rd;
            cnt    <= '0;
          end
        end
        ISSUE: begin
          cnt <= cnt + 16'd1;
          if (alu_ack) begin
            done_rd    <= rd_q;
            done_data  <= alu_result;
            done_flags <= alu_flags;
            done_err   <= 1'b0;
          end else if (tmo_hit) begin
            done_rd    <= rd_q;
            done_data  <= '0;
            done_flags <= '0;
            done_err   <= 1'b1;
          end
        end
        WRITE: begin
          if (!done_err && (done_rd != '0)) regs[done_rd] <= done_data;
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_STATS_EN
  // Saturating completion counters, bumped once per WRITE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_ops      <= '0;
      stat_timeouts <= '0;
    end else if (state == WRITE) begin
      if (done_err) begin
        if (stat_timeouts != 16'hFFFF) stat_timeouts <= stat_timeouts + 16'd1;
      end else begin
        if (stat_ops != 16'hFFFF) stat_ops <= stat_ops + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb_alu_cmd_issuer: directed + randomized commands against a scoreboard of
// expected completions and a shadow register file; ALU is emulated by the bench.
module tb_alu_cmd_issuer;
  localparam int DW = 32, OW = 4, NR = 8, TMO = 4, RW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [OW-1:0] cmd_op;
  logic [RW-1:0] cmd_rs1, cmd_rs2, cmd_rd;
  logic          cmd_imm_en;
  logic [DW-1:0] cmd_imm;
  logic          alu_req;
  logic [OW-1:0] alu_op;
  logic [DW-1:0] alu_a, alu_b;
  logic          alu_ack;
  logic [DW-1:0] alu_result;
  logic [3:0]    alu_flags;
  logic          done_valid;
  logic [RW-1:0] done_rd;
  logic [DW-1:0] done_data;
  logic [3:0]    done_flags;
  logic          done_err;
  logic [RW-1:0] dbg_addr;
  logic [DW-1:0] dbg_data;
  logic          busy;
`ifdef ALU_STATS_EN
  logic [15:0]   stat_ops, stat_timeouts;
`endif

  alu_cmd_issuer #(.DATA_W(DW), .OP_W(OW), .NREGS(NR), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_imm_en(cmd_imm_en),
    .cmd_imm(cmd_imm), .cmd_rd(cmd_rd),
    .alu_req(alu_req), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_ack(alu_ack), .alu_result(alu_result), .alu_flags(alu_flags),
    .done_valid(done_valid), .done_rd(done_rd), .done_data(done_data),
    .done_flags(done_flags), .done_err(done_err),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
`ifdef ALU_STATS_EN
    .stat_ops(stat_ops), .stat_timeouts(stat_timeouts),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [RW-1:0] rd;
    logic [DW-1:0] data;
    logic [3:0]    flags;
    logic          err;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] mregs [NR];
  int            checks = 0;
  int            failures = 0;
  int            n_ops = 0, n_tmo = 0;
  int            acc_cyc = 0, prev_acc = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_dbg(input logic [RW-1:0] a, input string tag);
    dbg_addr = a;
    #1;
    chk(tag, 64'(dbg_data), 64'(mregs[a]));
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with it idle again.
  // ack_at: request cycle (1-based) in which the ALU acks; 0 or >TMO means never.
  task automatic do_cmd(input logic [OW-1:0] op, input logic [RW-1:0] rs1,
                        input logic [RW-1:0] rs2, input logic imm_en,
                        input logic [DW-1:0] imm, input logic [RW-1:0] rd,
                        input int ack_at, input logic [DW-1:0] res,
                        input logic [3:0] flg);
    exp_t          e;
    logic [DW-1:0] ea, eb;
    int            req_n, exp_req;
    bit            got;
    ea = mregs[rs1];
    eb = imm_en ? imm : mregs[rs2];
    e.rd    = rd;
    e.err   = !(ack_at >= 1 && ack_at <= TMO);
    e.data  = e.err ? '0 : res;
    e.flags = e.err ? 4'h0 : flg;
    exp_req = e.err ? TMO : ack_at;
    sb.push_back(e);
    if (!e.err && rd != 0) mregs[rd] = res;
    if (e.err) n_tmo++; else n_ops++;

    cmd_op = op; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm_en = imm_en;
    cmd_imm = imm; cmd_rd = rd; cmd_valid = 1'b1;
    chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    @(posedge clk);
    prev_acc = acc_cyc;
    acc_cyc  = cyc;
    req_n = 0;
    got   = 0;
    for (int c = 0; c < TMO + 6 && !got; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (alu_req) begin
        req_n++;
        if (req_n == 1) begin
          chk("alu_op", 64'(alu_op), 64'(op));
          chk("alu_a", 64'(alu_a), 64'(ea));
          chk("alu_b", 64'(alu_b), 64'(eb));
        end
        alu_ack    = (req_n == ack_at);
        alu_result = res;
        alu_flags  = flg;
      end else begin
        alu_ack = 1'b0;
      end
      if (done_valid) begin
        got = 1;
        if (sb.size() == 0) begin
          chk("sb_nonempty", 64'd0, 64'd1);
        end else begin
          e = sb.pop_front();
          chk("done_rd", 64'(done_rd), 64'(e.rd));
          chk("done_data", 64'(done_data), 64'(e.data));
          chk("done_flags", 64'(done_flags), 64'(e.flags));
          chk("done_err", 64'(done_err), 64'(e.err));
        end
      end
    end
    chk("done_seen", 64'(got), 64'd1);
    chk("req_cycles", 64'(req_n), 64'(exp_req));
    @(negedge clk);
    chk("done_one_cycle", 64'(done_valid), 64'd0);
    chk("idle_after", 64'(busy), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < NR; i++) mregs[i] = '0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_rs1 = '0; cmd_rs2 = '0;
    cmd_imm_en = 1'b0; cmd_imm = '0; cmd_rd = '0; alu_ack = 1'b0;
    alu_result = '0; alu_flags = '0; dbg_addr = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_alu_req", 64'(alu_req), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done_valid", 64'(done_valid), 64'd0);
    chk("rst_done_data", 64'(done_data), 64'd0);
    chk_dbg(3'd5, "rst_dbg5");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Basic immediate add into r3
    do_cmd(4'd1, 3'd0, 3'd0, 1'b1, 32'h5, 3'd3, 1, 32'h5, 4'h0);
    chk_dbg(3'd3, "basic_r3");

    // Dependent command reads r3 just written; must be accepted 3 cycles later
    do_cmd(4'd2, 3'd3, 3'd3, 1'b0, 32'h0, 3'd4, 1, 32'hA, 4'h1);
    chk("b2b_spacing", 64'(acc_cyc - prev_acc), 64'd3);
    chk_dbg(3'd4, "dep_r4");

    // Timeout: no ack, r5 must stay 0
    do_cmd(4'd3, 3'd3, 3'd0, 1'b1, 32'h7, 3'd5, 0, 32'h99, 4'hF);
    chk_dbg(3'd5, "tmo_r5");

    // Ack exactly on the timeout cycle wins
    do_cmd(4'd4, 3'd4, 3'd3, 1'b0, 32'h0, 3'd6, TMO, 32'h1234, 4'hA);
    chk_dbg(3'd6, "ack_on_tmo_r6");

    // Write to r0 still completes but is discarded
    do_cmd(4'd5, 3'd6, 3'd0, 1'b1, 32'h1, 3'd0, 2, 32'hDEAD, 4'h2);
    chk_dbg(3'd0, "r0_zero");

    // Randomized commands, some timing out
    for (int k = 0; k < 8; k++) begin
      do_cmd(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
             3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom,
             3'($urandom_range(0, 7)), $urandom_range(1, TMO + 1), $urandom,
             4'($urandom_range(0, 15)));
    end
    for (int a = 0; a < NR; a++) chk_dbg(3'(a), "rand_regs");

`ifdef ALU_STATS_EN
    chk("stat_ops", 64'(stat_ops), 64'(n_ops));
    chk("stat_timeouts", 64'(stat_timeouts), 64'(n_tmo));
`endif

    // Reset in the middle of ISSUE
    cmd_op = 4'd1; cmd_rs1 = 3'd0; cmd_imm_en = 1'b1; cmd_imm = 32'h77;
    cmd_rd = 3'd2; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("pre_rst_req", 64'(alu_req), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_req", 64'(alu_req), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_done", 64'(done_valid), 64'd0);
    for (int i = 0; i < NR; i++) mregs[i] = '0;
    n_ops = 0; n_tmo = 0;
    for (int a = 0; a < NR; a++) chk_dbg(3'(a), "mid_rst_dbg");
    @(negedge clk);
    chk("rst_no_done", 64'(done_valid), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Normal operation resumes after reset
    do_cmd(4'd7, 3'd0, 3'd0, 1'b1, 32'h42, 3'd7, 3, 32'h42, 4'h4);
    chk_dbg(3'd7, "post_rst_r7");
    chk("sb_drained", 64'(sb.size()), 64'd0);
`ifdef ALU_STATS_EN
    chk("stat_ops_post", 64'(stat_ops), 64'(n_ops));
    chk("stat_tmo_post", 64'(stat_timeouts), 64'(n_tmo));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end
endmodule
